fetch_stage: RTL

Instruction-fetch stage of the 32-bit pipelined MIPS core. It owns the program counter, drives the word address into the combinational-read instruction memory, and captures the returned word into the IF/ID pipeline register. It also handles stalls, flushes, branch/jump redirects, a one-cycle boot bubble and out-of-range fetch faults. It sits directly upstream of the instruction memory and feeds the decode stage.

---
 rtl/fetch_stage_if.sv | 61 ++++++
 rtl/fetch_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's pipeline-control, instruction-memory and
// IF/ID signals. The "master" view belongs to the fetch stage itself. The
// "slave" view is for the surrounding pipeline: hazard unit, branch
// resolution, instruction memory and decode.
`timescale 1ns/1ps

interface fetch_stage_if #(
  parameter int PC_WIDTH = 32
) ();

  // Pipeline control from hazard unit / branch resolution
  logic                stall;
  logic                flush;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_target;

  // Instruction memory (combinational read)
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_instr;

  // IF/ID pipeline register towards decode
  logic                if_id_valid;
  logic [PC_WIDTH-1:0] if_id_pc;
  logic [PC_WIDTH-1:0] if_id_pc_plus1;
  logic [31:0]         if_id_instr;

  // Status
  logic                fetch_fault;
  logic [31:0]         fetch_count;

  modport master (
    input  stall,
    input  flush,
    input  redirect_valid,
    input  redirect_target,
    output imem_addr,
    input  imem_instr,
    output if_id_valid,
    output if_id_pc,
    output if_id_pc_plus1,
    output if_id_instr,
    output fetch_fault,
    output fetch_count
  );

  modport slave (
    output stall,
    output flush,
    output redirect_valid,
    output redirect_target,
    input  imem_addr,
    output imem_instr,
    input  if_id_valid,
    input  if_id_pc,
    input  if_id_pc_plus1,
    input  if_id_instr,
    input  fetch_fault,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the pipelined MIPS core.
// - Owns the word-addressed PC and presents it straight to the instruction memory.
// - Captures the returned word into the IF/ID register.
// - Spends one boot cycle after reset before the first fetch.
// - Priority in RUN is: redirect, then range fault, then stall, then flush,
//   then normal fetch.
// - An out-of-range PC parks the stage in HALT until reset.
`timescale 1ns/1ps

module fetch_stage #(
  parameter int                   PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = {PC_WIDTH{1'b0}},
  parameter longint unsigned      IMEM_DEPTH = 64'd1024
) (
  input  logic            clk,
  input  logic            rst,
  fetch_stage_if.master   bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [PC_WIDTH-1:0] PC_ZERO = {PC_WIDTH{1'b0}};
  localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // Depth is held one bit wider than the PC. This lets a depth of
  // 2^PC_WIDTH mark every PC as valid.
  localparam logic [64:0] DEPTH_EXT = 65'(IMEM_DEPTH);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [PC_WIDTH-1:0] id_pc1_q, id_pc1_d;
  logic [31:0]         instr_q, instr_d;
  logic                fault_q, fault_d;
  logic [31:0]         count_q, count_d;

  logic [PC_WIDTH-1:0] pc_plus1_s;
  logic                out_of_range_s;
  logic                capture_s;
  logic                bubble_s;

  assign pc_plus1_s     = pc_q + PC_ONE;
  assign out_of_range_s = (65'(pc_q) >= DEPTH_EXT);

  // Next-state, PC and IF/ID selection following the per-edge priority rules
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
    count_d   = count_q;
    capture_s = 1'b0;
    bubble_s  = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // No fetch yet: PC holds while a bubble enters IF/ID
        bubble_s = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (bus.redirect_valid) begin
          // The target is accepted even when out of range; the range check
          // happens when that PC is actually fetched next cycle.
          pc_d     = bus.redirect_target;
          bubble_s = 1'b1;
        end else if (out_of_range_s) begin
          state_d  = ST_HALT;
          fault_d  = 1'b1;
          bubble_s = 1'b1;
        end else if (bus.stall) begin
          // Everything holds; flush is deliberately ignored here
          bubble_s = 1'b0;
        end else if (bus.flush) begin
          pc_d     = pc_plus1_s;
          bubble_s = 1'b1;
        end else begin
          pc_d      = pc_plus1_s;
          capture_s = 1'b1;
          count_d   = count_q + 32'd1;
        end
      end
      ST_HALT: begin
        // Parked until reset: IF/ID keeps receiving bubbles
        bubble_s = 1'b1;
      end
      default: begin
        // Unreachable encoding: recover through the boot cycle
        state_d  = ST_BOOT;
        bubble_s = 1'b1;
      end
    endcase
  end

  // IF/ID next contents: capture, bubble or hold
  always_comb begin
    valid_d  = valid_q;
    id_pc_d  = id_pc_q;
    id_pc1_d = id_pc1_q;
    instr_d  = instr_q;
    if (capture_s) begin
      valid_d  = 1'b1;
      id_pc_d  = pc_q;
      id_pc1_d = pc_plus1_s;
      instr_d  = bus.imem_instr;
    end else if (bubble_s) begin
      valid_d  = 1'b0;
      id_pc_d  = PC_ZERO;
      id_pc1_d = PC_ZERO;
      instr_d  = 32'd0;
    end else begin
      valid_d  = valid_q;
    end
  end

  // State, PC, IF/ID and status registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      id_pc_q  <= PC_ZERO;
      id_pc1_q <= PC_ZERO;
      instr_q  <= 32'd0;
      fault_q  <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      id_pc_q  <= id_pc_d;
      id_pc1_q <= id_pc1_d;
      instr_q  <= instr_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.if_id_pc       = id_pc_q;
  assign bus.if_id_pc_plus1 = id_pc1_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.fetch_fault    = fault_q;
  assign bus.fetch_count    = count_q;

endmodule
